// File: rtl/interrupt_controller.sv
// interrupt_controller: interrupt scheduler for the 8051 core.
// Polls five sources at qualified instruction boundaries and raises a
// hardware LCALL request toward control_unit. Tracks high/low in-service
// levels until RETI.
// Build option: define INT_PRIORITY_EN for two-level priority with nesting;
// without it, ip is ignored and any active handler blocks polling.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; polls at unblocked instruction boundaries
// REQ   | request committed; int_req/vector_addr held until int_ack
module interrupt_controller #(
  parameter int          NUM_SRC       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0003,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [7:0]         ie,
  input  logic [NUM_SRC-1:0] ip,
  input  logic               instr_boundary,
  input  logic               block_poll,
  input  logic               reti,
  input  logic               int_ack,
  output logic               int_req,
  output logic [15:0]        vector_addr,
  output logic [NUM_SRC-1:0] clr_flag,
  output logic [1:0]         in_service
);

  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]         state;
  logic [IDXW-1:0]    lat_idx;
  logic               lat_lvl;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] hi_cand;
  logic [NUM_SRC-1:0] lo_cand;
  logic               hi_found;
  logic               lo_found;
  logic [IDXW-1:0]    hi_idx;
  logic [IDXW-1:0]    lo_idx;
  logic               win_found;
  logic               win_lvl;
  logic [IDXW-1:0]    win_idx;
  logic               poll;
  logic               ack_take;
  logic [1:0]         is_after_reti;
  logic [1:0]         is_set_mask;
  logic               unused_ok;

  // Bits of ie/ip that some builds never look at.
  assign unused_ok = ^{ie, ip};

  assign elig = src_req & ie[NUM_SRC-1:0] & {NUM_SRC{ie[7]}};

`ifdef INT_PRIORITY_EN
  // High level may preempt a low handler; low level needs nothing in service.
  assign hi_cand = in_service[1] ? '0 : (elig & ip);
  assign lo_cand = (in_service == 2'b00) ? (elig & ~ip) : '0;
`else
  // Single level: everything is low priority, and any handler blocks polling.
  assign hi_cand = '0;
  assign lo_cand = in_service[0] ? '0 : elig;
`endif

  // Lowest-index high-level candidate.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (hi_cand[i]) begin
        hi_found = 1'b1;
        hi_idx   = IDXW'(i);
      end
    end
  end

  // Lowest-index low-level candidate.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (lo_cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDXW'(i);
      end
    end
  end

  assign win_found = hi_found | lo_found;
  assign win_lvl   = hi_found;
  assign win_idx   = hi_found ? hi_idx : lo_idx;

  assign poll     = (state == IDLE) && instr_boundary && !block_poll;
  assign ack_take = (state == REQ) && int_ack;

  // RETI retires the innermost level; a same-edge ack then sets its level.
  always_comb begin
    is_after_reti = in_service;
    if (reti) begin
      if (in_service[1]) is_after_reti[1] = 1'b0;
      else               is_after_reti[0] = 1'b0;
    end
    is_set_mask = 2'b00;
    if (ack_take) is_set_mask = lat_lvl ? 2'b10 : 2'b01;
  end

  // Request FSM, committed vector and one-cycle flag clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      int_req     <= 1'b0;
      vector_addr <= '0;
      clr_flag    <= '0;
      lat_idx     <= '0;
      lat_lvl     <= 1'b0;
    end else begin
      clr_flag <= '0;
      case (state)
        IDLE: begin
          if (poll && win_found) begin
            state       <= REQ;
            int_req     <= 1'b1;
            vector_addr <= VECTOR_BASE + 16'(win_idx) * 16'(VECTOR_STRIDE);
            lat_idx     <= win_idx;
            lat_lvl     <= win_lvl;
          end
        end
        REQ: begin
          if (int_ack) begin
            state    <= IDLE;
            int_req  <= 1'b0;
            clr_flag <= NUM_SRC'(1) << lat_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-service tracking: clear on RETI, set on acknowledged grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_service <= 2'b00;
    end else begin
      in_service <= is_after_reti | is_set_mask;
    end
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Interrupt scheduler for the 8051 core.
- Arbitrates five interrupt sources against the IE/IP settings and samples requests only at instruction boundaries.
- Asks the control unit to insert a hardware LCALL to the winning vector.
- Tracks the high- and low-level in-service state until RETI.
- Sits beside control_unit; its handshake gates the next Fetch.

Parameters:
- NUM_SRC, 5, number of interrupt sources; index 0..4 = INT0, TF0, INT1, TF1, RI|TI.
- VECTOR_BASE, 16'h0003, vector address of source 0.
- VECTOR_STRIDE, 8, address spacing between consecutive vectors.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_req  in  NUM_SRC  latched request flags from peripherals, level-sensitive.
- ie  in  8  IE SFR; bit7 = EA, bits NUM_SRC-1..0 = per-source enables.
- ip  in  NUM_SRC  IP SFR; 1 = high priority.
- instr_boundary  in  1  one-cycle pulse in the last Execute cycle of each instruction.
- block_poll  in  1  qualifies instr_boundary; current instruction is RETI or writes IE/IP.
- reti  in  1  one-cycle pulse when RETI executes.
- int_ack  in  1  one-cycle pulse from control_unit when LCALL insertion begins.
- int_req  out  1  interrupt pending, LCALL required.
- vector_addr  out  16  vector of the granted source.
- clr_flag  out  NUM_SRC  one-hot, one-cycle clear strobe to the source flag.
- in_service  out  2  {high, low} in-service bits.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, named clock and reset.
- Reset values: state = IDLE, int_req = 0, vector_addr = 0, clr_flag = 0, in_service = 2'b00.
- FSM states: IDLE, REQ.
- Polling:
  - Polling happens in IDLE only, on a cycle with instr_boundary = 1 and block_poll = 0.
  - Eligible sources: src_req[i] & ie[i] & ie[7].
  - A high-level candidate (ip[i] = 1) wins only if in_service[1] = 0.
  - A low-level candidate wins only if in_service = 2'b00.
  - High level beats low level; within a level, the lowest index wins.
- IDLE -> REQ:
  - Taken when a winner exists at a qualified boundary.
  - On the next edge: int_req = 1; vector_addr = VECTOR_BASE + idx*VECTOR_STRIDE, computed in 16 bits; the winner's index and level are latched.
  - Latency from boundary to int_req is 1 cycle.
- REQ:
  - int_req and vector_addr stay stable until int_ack.
  - The request is committed. Later changes to src_req, ie or ip do not withdraw or alter it.
- REQ -> IDLE:
  - Taken on int_ack.
  - On that edge: int_req = 0; the latched level's in_service bit is set; clr_flag[idx] = 1 for exactly one cycle.
- int_ack in IDLE is ignored.
- instr_boundary while in REQ is ignored; no re-poll.
- reti:
  - Clears in_service[1] if it is set, otherwise in_service[0].
  - No effect if in_service = 00.
- reti and int_ack on the same edge: the clear is applied first, then the set.
- block_poll = 1 with instr_boundary: polling is skipped for that boundary. At least one more instruction completes before an interrupt is taken.
- Reset mid-REQ: immediate return to IDLE; the pending request is lost.

Optional Feature:
- Macro: INT_PRIORITY_EN.
- Defined: two-level priority with nesting, exactly as described above.
- Undefined:
  - ip is ignored and all sources are treated as low level.
  - in_service[1] is held at 0.
  - Any set in_service[0] blocks all polling; no nesting.

Test Plan:
- Single source: src_req = 5'b00010, ie = 8'h82, instr_boundary pulse -> int_req = 1 next cycle, vector_addr = 16'h000B. int_ack -> clr_flag = 5'b00010 for 1 cycle, in_service = 01.
- Priority: src_req = 5'b00011, ie = 8'h83, ip = 5'b00010 -> vector 16'h000B (TF0, high level wins). With ip = 0 -> vector 16'h0003.
- Nesting:
  - Low level in service (in_service = 01); high-level INT1 arrives at a boundary -> vector 16'h0013, in_service = 11.
  - First reti -> in_service = 01; second reti -> in_service = 00.
  - A same-level request while in_service = 01 is not granted.
- Boundary rules:
  - block_poll = 1 with a pending source -> no int_req; the next unblocked boundary grants it.
  - EA = 0 -> never granted.
  - Clearing ie while in REQ -> int_req stays 1 until int_ack.
- Reset mid-REQ: assert reset while int_req = 1 -> int_req, clr_flag and in_service are 0 immediately, without waiting for a clock edge; after release, a fresh boundary re-polls.
